// File: rtl/stopwatch_controller.sv
`timescale 1ns/1ps
// stopwatch_controller
//   Start/stop/lap/reset sequencer for a stopwatch time counter. Buttons are
//   sampled only on rising edges of the slow clock clk_sl (used as a level),
//   which debounces them. A press event is a sampled 0->1 transition and is
//   valid for the single clk_ms cycle after the slow edge.
//
//   state | meaning
//   ------+-----------------------------------------
//   IDLE  | 00, stopped with counter at zero
//   RUN   | 01, counting, display shows live counter
//   STOP  | 10, stopped with counter nonzero
//   LAP   | 11, counting, display frozen on lap register
//
// Ports
//   clk_ms         master clock, all registers update on its rising edge
//   rst            asynchronous active-high reset
//   clk_sl         slow sampling clock, sampled as a level
//   btn_startstop  start/stop button level, 1 = pressed
//   btn_reset      reset button level, 1 = pressed
//   btn_lap        lap button level, 1 = pressed
//   tick_in        timebase strobe, one clk_ms cycle wide
//   count_inc      increment strobe to the time counter (combinational)
//   count_clr      registered synchronous clear pulse to the time counter
//   lap_latch      registered one-cycle strobe to capture the lap register
//   lap_hold       1 = display shows lap register
//   state          current FSM state encoding
module stopwatch_controller (
  input  logic       clk_ms,
  input  logic       rst,
  input  logic       clk_sl,
  input  logic       btn_startstop,
  input  logic       btn_reset,
  input  logic       btn_lap,
  input  logic       tick_in,
  output logic       count_inc,
  output logic       count_clr,
  output logic       lap_latch,
  output logic       lap_hold,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10,
    LAP  = 2'b11
  } state_t;

  state_t state_q;

  // Button vectors are ordered {lap, reset, startstop}.
  logic       clk_sl_prev;
  logic       slow_edge;
  logic       ev_valid;
  logic [2:0] smp;
  logic [2:0] smp_prev;
  logic [2:0] press;
  logic       ev_ss;
  logic       ev_rst;
  logic       ev_lap;

  assign slow_edge = clk_sl & ~clk_sl_prev;

  always_ff @(posedge clk_ms or posedge rst) begin
    if (rst) begin
      clk_sl_prev <= 1'b0;
      ev_valid    <= 1'b0;
      smp         <= 3'b000;
      smp_prev    <= 3'b000;
    end else begin
      clk_sl_prev <= clk_sl;
      // ev_valid qualifies the press vector for exactly the cycle after the
      // slow edge; the sample pair itself stays frozen until the next edge.
      ev_valid    <= slow_edge;
      if (slow_edge) begin
        smp      <= {btn_lap, btn_reset, btn_startstop};
        smp_prev <= smp;
      end
    end
  end

  assign press  = smp & ~smp_prev & {3{ev_valid}};
  assign ev_ss  = press[0];
  assign ev_rst = press[1];
  assign ev_lap = press[2];

  // Each branch tests events in priority order reset > startstop > lap,
  // skipping events that have no meaning in that state, so the highest
  // valid event acts and the rest are dropped.
  always_ff @(posedge clk_ms or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lap_hold  <= 1'b0;
      lap_latch <= 1'b0;
      count_clr <= 1'b1;
    end else begin
      count_clr <= 1'b0;
      lap_latch <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ev_rst) begin
            count_clr <= 1'b1;
          end else if (ev_ss) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (ev_ss) begin
            state_q <= STOP;
          end else if (ev_lap) begin
            state_q   <= LAP;
            lap_hold  <= 1'b1;
            lap_latch <= 1'b1;
          end
        end
        STOP: begin
          if (ev_rst) begin
            state_q   <= IDLE;
            count_clr <= 1'b1;
          end else if (ev_ss) begin
            state_q <= RUN;
          end
        end
        LAP: begin
          if (ev_rst) begin
            state_q  <= RUN;
            lap_hold <= 1'b0;
          end else if (ev_ss) begin
            state_q  <= STOP;
            lap_hold <= 1'b0;
          end else if (ev_lap) begin
            lap_latch <= 1'b1;
          end
        end
      endcase
    end
  end

  // Uses the pre-transition state, so a tick coinciding with a state change
  // is gated by the state that was current during that cycle.
  assign count_inc = tick_in & ((state_q == RUN) | (state_q == LAP));
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
`timescale 1ns/1ps
// tb_stopwatch_controller
//   Directed bench for stopwatch_controller. Stimulus pushes expected output
//   snapshots tagged with the clk_ms cycle they belong to; a monitor on the
//   falling edge pops and compares them.
module tb_stopwatch_controller;

  logic       clk_ms = 1'b0;
  logic       rst;
  logic       clk_sl;
  logic       btn_startstop;
  logic       btn_reset;
  logic       btn_lap;
  logic       tick_in;
  logic       count_inc;
  logic       count_clr;
  logic       lap_latch;
  logic       lap_hold;
  logic [1:0] state;

  stopwatch_controller dut (
    .clk_ms        (clk_ms),
    .rst           (rst),
    .clk_sl        (clk_sl),
    .btn_startstop (btn_startstop),
    .btn_reset     (btn_reset),
    .btn_lap       (btn_lap),
    .tick_in       (tick_in),
    .count_inc     (count_inc),
    .count_clr     (count_clr),
    .lap_latch     (lap_latch),
    .lap_hold      (lap_hold),
    .state         (state)
  );

  always #5 clk_ms = ~clk_ms;

  typedef struct {
    int         id;
    int         ph;
    int         cyc;
    logic [1:0] st;
    logic       hold;
    logic       clr;
    logic       latch;
    logic       inc;
  } exp_t;

  exp_t expq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   vec_id = 0;

  logic [1:0] prev_st;
  logic       prev_hold;
  logic       prev_inc;

  always @(posedge clk_ms) cyc <= cyc + 1;

  always @(negedge clk_ms) begin
    exp_t e;
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      e = expq.pop_front();
      checks++;
      if (e.cyc != cyc ||
          {state, lap_hold, count_clr, lap_latch, count_inc} !==
          {e.st, e.hold, e.clr, e.latch, e.inc}) begin
        failures++;
        $display("FAIL vec%0d.p%0d cyc=%0d/%0d got st=%b hold=%b clr=%b latch=%b inc=%b want st=%b hold=%b clr=%b latch=%b inc=%b",
                 e.id, e.ph, cyc, e.cyc, state, lap_hold, count_clr, lap_latch, count_inc,
                 e.st, e.hold, e.clr, e.latch, e.inc);
      end
    end
  end

  task automatic step();
    @(posedge clk_ms);
    #2;
  endtask

  task automatic push(input int id, input int ph, input int c, input logic [1:0] st,
                      input logic hold, input logic clr, input logic latch, input logic inc);
    exp_t e;
    e.id = id; e.ph = ph; e.cyc = c; e.st = st;
    e.hold = hold; e.clr = clr; e.latch = latch; e.inc = inc;
    expq.push_back(e);
  endtask

  // Apply button levels b = {lap, reset, startstop} at one slow edge E and
  // check: no change at E (tick gated by old state), new state and strobes at
  // E+1, strobes gone at E+2, then nticks tick strobes in the new state.
  task automatic run_vec(input logic [2:0] b, input logic [1:0] st, input logic hold,
                         input logic clr, input logic latch, input int nticks,
                         input logic inc);
    vec_id++;
    btn_startstop = b[0];
    btn_reset     = b[1];
    btn_lap       = b[2];
    clk_sl = 1'b1;
    step();
    clk_sl  = 1'b0;
    tick_in = 1'b1;
    push(vec_id, 0, cyc, prev_st, prev_hold, 1'b0, 1'b0, prev_inc);
    step();
    tick_in = 1'b0;
    push(vec_id, 1, cyc, st, hold, clr, latch, 1'b0);
    step();
    push(vec_id, 2, cyc, st, hold, 1'b0, 1'b0, 1'b0);
    step();
    prev_st = st; prev_hold = hold; prev_inc = inc;
    for (int i = 0; i < nticks; i++) begin
      tick_in = 1'b1;
      push(vec_id, 3, cyc, st, hold, 1'b0, 1'b0, inc);
      step();
      tick_in = 1'b0;
      push(vec_id, 4, cyc, st, hold, 1'b0, 1'b0, 1'b0);
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clk_sl = 1'b0; tick_in = 1'b0;
    btn_startstop = 1'b0; btn_reset = 1'b0; btn_lap = 1'b0;
    prev_st = 2'b00; prev_hold = 1'b0; prev_inc = 1'b0;

    // Reset with clk_sl toggling and ticks arriving
    for (int i = 0; i < 4; i++) begin
      clk_sl  = i[0];
      tick_in = 1'b1;
      step();
    end
    clk_sl = 1'b0;
    step();
    push(100, 0, cyc, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    push(100, 1, cyc, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    push(100, 2, cyc, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_in = 1'b0;
    step();

    //       b       st     hold  clr   latch ticks inc
    run_vec(3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    run_vec(3'b010, 2'b00, 1'b0, 1'b1, 1'b0, 0, 1'b0); // reset in IDLE: clr pulse
    run_vec(3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_vec(3'b100, 2'b00, 1'b0, 1'b0, 1'b0, 1, 1'b0); // lap ignored in IDLE
    run_vec(3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_vec(3'b001, 2'b01, 1'b0, 1'b0, 1'b0, 5, 1'b1); // start, 5 ticks counted
    run_vec(3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_vec(3'b010, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b1); // reset ignored in RUN
    run_vec(3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_vec(3'b100, 2'b11, 1'b1, 1'b0, 1'b1, 3, 1'b1); // lap
    run_vec(3'b000, 2'b11, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    run_vec(3'b100, 2'b11, 1'b1, 1'b0, 1'b1, 0, 1'b1); // new lap
    run_vec(3'b000, 2'b11, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    run_vec(3'b010, 2'b01, 1'b0, 1'b0, 1'b0, 2, 1'b1); // reset in LAP releases display
    run_vec(3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_vec(3'b001, 2'b10, 1'b0, 1'b0, 1'b0, 3, 1'b0); // stop, ticks gated
    run_vec(3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_vec(3'b100, 2'b10, 1'b0, 1'b0, 1'b0, 0, 1'b0); // lap ignored in STOP
    run_vec(3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_vec(3'b001, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_vec(3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_vec(3'b111, 2'b10, 1'b0, 1'b0, 1'b0, 0, 1'b0); // all pressed in RUN: stop only
    run_vec(3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_vec(3'b010, 2'b00, 1'b0, 1'b1, 1'b0, 0, 1'b0); // reset in STOP
    run_vec(3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_vec(3'b001, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_vec(3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 10; i++)                       // held startstop: one event
      run_vec(3'b001, 2'b10, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_vec(3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_vec(3'b001, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_vec(3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_vec(3'b100, 2'b11, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    run_vec(3'b000, 2'b11, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    run_vec(3'b011, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b1); // reset beats startstop in LAP
    run_vec(3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_vec(3'b100, 2'b11, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    run_vec(3'b000, 2'b11, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    run_vec(3'b001, 2'b10, 1'b0, 1'b0, 1'b0, 0, 1'b0); // startstop in LAP
    run_vec(3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_vec(3'b001, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_vec(3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_vec(3'b100, 2'b11, 1'b1, 1'b0, 1'b1, 0, 1'b1);

    // Asynchronous reset mid-cycle in LAP, startstop held through release
    btn_lap = 1'b0; btn_startstop = 1'b1; tick_in = 1'b1;
    #1;
    rst = 1'b1;
    push(200, 0, cyc, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    push(200, 1, cyc, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    push(200, 2, cyc, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tick_in = 1'b0;
    prev_st = 2'b00; prev_hold = 1'b0; prev_inc = 1'b0;
    run_vec(3'b001, 2'b01, 1'b0, 1'b0, 1'b0, 1, 1'b1); // held button registers as press

    repeat (4) step();
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
